mskand_hpc3_rnd_feeder: RTL and testbench

- Width-adapting randomness buffer between the PRNG and a bank of HPC3 masked AND gadgets.
- Accepts IN_W fresh random bits per PRNG handshake and delivers OUT_W bits per consumption, i.e. NGADGETS times hpc3rnd bits with hpc3rnd = d*(d-1).
- Bits are delivered in strict arrival order. No bit is ever delivered twice.
- Sits directly upstream of the gadgets' rnd inputs. Its output drives their rnd buses combinationally in the cycle the gadget pipeline advances.

---
 rtl/mskand_hpc3_rnd_feeder_if.sv | 34 +++
 rtl/mskand_hpc3_rnd_feeder.sv | 86 ++++++++
 tb/tb_mskand_hpc3_rnd_feeder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mskand_hpc3_rnd_feeder_if.sv
// Handshake bundle between the PRNG (in_*) and the HPC3 gadget bank (out_*).
// slave is the feeder side; master is the side that drives PRNG words and consumes randomness.
interface mskand_hpc3_rnd_feeder_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
);
    // A word moves on in_* when in_valid & in_ready are both high at a rising edge;
    // OUT_W bits move on out_* when out_valid & out_ready are both high at a rising edge.
    // Neither valid waits on its ready, and neither ready depends on the opposite valid.
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_rnd;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_rnd;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_rnd,
        output out_valid,
        input  out_ready,
        output out_rnd
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_rnd,
        input  out_valid,
        output out_ready,
        input  out_rnd
    );
endinterface

// File: rtl/mskand_hpc3_rnd_feeder.sv
// Width-adapting randomness buffer feeding IN_W-bit PRNG words to a bank of HPC3 AND gadgets.
// Optional macro RND_STALL_CNT_EN adds a saturating stall_cnt output.
module mskand_hpc3_rnd_feeder #(
    parameter int d        = 2,
    parameter int NGADGETS = 16,
    parameter int IN_W     = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    mskand_hpc3_rnd_feeder_if.slave rnd_if
`ifdef RND_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam int HPC3RND = d * (d - 1);
    localparam int OUT_W   = NGADGETS * HPC3RND;
    localparam int BUF_W   = OUT_W + IN_W;
    localparam int LW      = $clog2(BUF_W + 1);
    localparam int NET     = (IN_W >= OUT_W) ? (IN_W - OUT_W) : (OUT_W - IN_W);

    logic [BUF_W-1:0] rnd_buf, buf_d, shifted;
    logic [LW-1:0]    level, level_d, wr_pos;
    logic             in_rdy, out_vld, push, pop;

    assign in_rdy  = (level <= LW'(OUT_W));
    assign out_vld = (level >= LW'(OUT_W));
    assign push    = rnd_if.in_valid & in_rdy;
    assign pop     = out_vld & rnd_if.out_ready;

    assign rnd_if.in_ready  = in_rdy;
    assign rnd_if.out_valid = out_vld;
    assign rnd_if.out_rnd   = rnd_buf[OUT_W-1:0];

    // Everything above level is kept zero, so an OR is enough to drop the new word in.
    always_comb begin
        shifted = rnd_buf;
        wr_pos  = level;
        buf_d   = rnd_buf;
        level_d = level;
        if (flush) begin
            buf_d   = '0;
            level_d = '0;
        end else begin
            if (pop) begin
                shifted = rnd_buf >> OUT_W;
                wr_pos  = level - LW'(OUT_W);
            end
            buf_d = shifted;
            if (push) begin
                buf_d = shifted | (BUF_W'(rnd_if.in_rnd) << wr_pos);
            end
            case ({push, pop})
                2'b10:   level_d = level + LW'(IN_W);
                2'b01:   level_d = level - LW'(OUT_W);
                2'b11: begin
                    if (IN_W >= OUT_W) level_d = level + LW'(NET);
                    else               level_d = level - LW'(NET);
                end
                default: level_d = level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_buf <= '0;
            level   <= '0;
        end else begin
            rnd_buf <= buf_d;
            level   <= level_d;
        end
    end

`ifdef RND_STALL_CNT_EN
    // Counts cycles where the gadgets wanted randomness but none was ready; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (rnd_if.out_ready && !out_vld && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mskand_hpc3_rnd_feeder.sv
// Directed and random bench for mskand_hpc3_rnd_feeder with a bit-stream scoreboard.
module tb_mskand_hpc3_rnd_feeder;
  localparam int IN_W  = 24;
  localparam int OUT_W = 32;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef RND_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] exp_stall;
`endif

  mskand_hpc3_rnd_feeder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) rnd_if ();

  mskand_hpc3_rnd_feeder #(.d(2), .NGADGETS(16), .IN_W(IN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .rnd_if (rnd_if.slave)
`ifdef RND_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: completed OUT_W words in exp_q, leftover stream bits in part_q
  logic [OUT_W-1:0] exp_q[$];
  bit               part_q[$];
  int               checks = 0;
  int               passes = 0;
  int               fails  = 0;

  function automatic int model_level();
    return exp_q.size() * OUT_W + part_q.size();
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    logic [OUT_W-1:0] v;
    v = '0;
    if (exp_q.size() > 0) v = exp_q[0];
    else for (int i = 0; i < part_q.size(); i++) v[i] = part_q[i];
    return v;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
  endtask

  task automatic model_push(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] v;
    for (int k = 0; k < IN_W; k++) part_q.push_back(w[k]);
    while (part_q.size() >= OUT_W) begin
      for (int i = 0; i < OUT_W; i++) v[i] = part_q.pop_front();
      exp_q.push_back(v);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int lvl;
    lvl = model_level();
    chk("in_ready", rnd_if.in_ready, lvl <= OUT_W);
    chk("out_valid", rnd_if.out_valid, lvl >= OUT_W);
    chk("out_rnd", rnd_if.out_rnd, model_out());
`ifdef RND_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  // driver: called at posedge+1, samples at negedge, updates the model at the next posedge
  task automatic step(input logic iv, input logic [IN_W-1:0] w, input logic ordy, input logic fl);
    int  lvl;
    bit  do_push, do_pop;
    rnd_if.in_valid  = iv;
    rnd_if.in_rnd    = w;
    rnd_if.out_ready = ordy;
    flush            = fl;
    @(negedge clk);
    check_outputs();
    lvl     = model_level();
    do_push = iv && (lvl <= OUT_W);
    do_pop  = ordy && (lvl >= OUT_W);
`ifdef RND_STALL_CNT_EN
    if (ordy && (lvl < OUT_W) && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
`endif
    @(posedge clk);
    if (fl) model_clear();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) model_push(w);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    rnd_if.in_valid  = 1'b0;
    rnd_if.in_rnd    = '0;
    rnd_if.out_ready = 1'b0;
`ifdef RND_STALL_CNT_EN
    exp_stall = '0;
`endif
    @(negedge clk);
    chk("rst_in_ready", rnd_if.in_ready, 1'b1);
    chk("rst_out_valid", rnd_if.out_valid, 1'b0);
    chk("rst_out_rnd", rnd_if.out_rnd, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // two pushes, no consumption: 0x56ABCDEF at level 48
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    step(1'b1, 24'h123456, 1'b0, 1'b0);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    chk("tp1_out_rnd", rnd_if.out_rnd, 32'h56ABCDEF);
    chk("tp1_in_ready", rnd_if.in_ready, 1'b0);

    // level 48: pop accepted, push refused because in_ready is low
    step(1'b1, 24'h777777, 1'b1, 1'b0);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    chk("tp2_low16", rnd_if.out_rnd[15:0], 16'h1234);
    chk("tp2_in_ready", rnd_if.in_ready, 1'b1);

    // reach level 32, then concurrent push and pop
    step(1'b1, 24'hA1B2C3, 1'b0, 1'b0);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    step(1'b1, 24'h5A5A5A, 1'b0, 1'b0);
    step(1'b1, 24'hFFFFFF, 1'b1, 1'b0);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    chk("tp3_out_rnd", rnd_if.out_rnd, 32'h00FFFFFF);
    chk("tp3_out_valid", rnd_if.out_valid, 1'b0);

    // 24 -> 48 -> 16 -> 40, then flush with both handshakes asserted
    step(1'b1, 24'h13579B, 1'b0, 1'b0);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    step(1'b1, 24'h2468AC, 1'b0, 1'b0);
    step(1'b1, 24'hDEAD01, 1'b1, 1'b1);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    chk("tp4_flush_rnd", rnd_if.out_rnd, 0);

    // flush while a push would be accepted: the word must not be stored
    step(1'b1, 24'hC0FFEE, 1'b0, 1'b0);
    step(1'b1, 24'hBADBAD, 1'b0, 1'b1);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    chk("flush_push_valid", rnd_if.out_valid, 1'b0);

    // back to level 40, then an asynchronous half-cycle reset pulse
    step(1'b1, 24'h111111, 1'b0, 1'b0);
    step(1'b1, 24'h222222, 1'b0, 1'b0);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    step(1'b1, 24'h333333, 1'b0, 1'b0);
    chk("tp5_pre_valid", rnd_if.out_valid, 1'b1);
    rnd_if.in_valid  = 1'b0;
    rnd_if.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("tp5_async_valid", rnd_if.out_valid, 1'b0);
    chk("tp5_async_ready", rnd_if.in_ready, 1'b1);
    chk("tp5_async_rnd", rnd_if.out_rnd, 0);
    #4 rst_n = 1'b1;
    model_clear();
`ifdef RND_STALL_CNT_EN
    exp_stall = '0;
`endif
    @(posedge clk);
    #1;
    step(1'b0, 24'h0, 1'b0, 1'b0);

    // random traffic checked against the stream scoreboard
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 3) != 0), IN_W'($urandom()),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end
    step(1'b0, 24'h0, 1'b0, 1'b0);

`ifdef RND_STALL_CNT_EN
    // saturation: reset, then starve the consumer for 70000 cycles
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
    rnd_if.in_valid  = 1'b0;
    rnd_if.out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stall_sat", stall_cnt, 16'hFFFF);
    rnd_if.out_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
